// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the RISC-V core.
// Accepts one load or store at a time over a REQ/READY handshake. It inserts
// WAIT_STATES wait cycles, applies byte/halfword/word lane masking on stores
// and sign/zero extension on loads. Misaligned accesses and illegal funct3
// codes are rejected without touching memory.
//
// Parameters:
//   DEPTH        memory size in 32-bit words (power of two, 16..65536)
//   WAIT_STATES  extra cycles between acceptance and READY (0..15)
// Ports:
//   CLK          rising-edge clock
//   RESET        synchronous, active-high reset
//   REQ          access request, held by the requester until READY
//   WE           1 = store, 0 = load
//   FUNCT3       RV32I funct3 (access size and extension)
//   ADDRESS      byte address; upper bits wrap modulo DEPTH*4
//   DATA_IN      store data, right-aligned
//   READY        one-cycle completion pulse
//   DATA_OUT     extended result of the last successful load
//   MISALIGNED   valid with READY; 1 = access rejected
module dmem_ctrl #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] DATA_IN,
    output logic        READY,
    output logic [31:0] DATA_OUT,
    output logic        MISALIGNED
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;

    // Latched request
    logic            we_q;
    logic [2:0]      f3_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic            ready_q;
    logic            mis_q;

    // Load result path: raw RAM word plus what is needed to extend it
    logic [31:0]     rdata_q;
    logic [2:0]      ld_f3_q;
    logic [1:0]      ld_off_q;

    logic [31:0]     mem_q [DEPTH];

    // Bits above the word index only alias the memory and are not decoded
    logic            unused_addr_bits;
    assign unused_addr_bits = ^ADDRESS[31:AW+2];

    // Access being handled: live inputs while in IDLE, latched copies after
    logic            acc_we;
    logic [2:0]      acc_f3;
    logic [AW+1:0]   acc_addr;

    always_comb begin
        acc_we   = we_q;
        acc_f3   = f3_q;
        acc_addr = addr_q;
        if (state_q == S_IDLE) begin
            acc_we   = WE;
            acc_f3   = FUNCT3;
            acc_addr = ADDRESS[AW+1:0];
        end
    end

    // Rejection decode: illegal funct3 or address not aligned to access size
    logic acc_legal;
    logic acc_misal;
    logic acc_bad;

    always_comb begin
        acc_legal = 1'b0;
        case ({acc_we, acc_f3})
            4'b1_000, 4'b1_001, 4'b1_010,
            4'b0_000, 4'b0_001, 4'b0_010,
            4'b0_100, 4'b0_101:  acc_legal = 1'b1;
            default:             acc_legal = 1'b0;
        endcase
        acc_misal = ((acc_f3[1:0] == 2'b01) && acc_addr[0]) ||
                    ((acc_f3[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
        acc_bad   = !acc_legal || acc_misal;
    end

    // Transition into DONE; the RAM read is issued on this same edge
    logic enter_done;
    logic rd_en;
    logic wr_en;

    always_comb begin
        enter_done = 1'b0;
        if (!RESET) begin
            if ((state_q == S_IDLE) && REQ && (WAIT_STATES == 0)) begin
                enter_done = 1'b1;
            end
            if ((state_q == S_WAIT) && (cnt_q == CW'(1))) begin
                enter_done = 1'b1;
            end
        end
        rd_en = enter_done && !acc_we && !acc_bad;
        // mis_q holds the rejection flag of the access sitting in DONE
        wr_en = (state_q == S_DONE) && !RESET && we_q && !mis_q;
    end

    // Store lane enables and lane-replicated write data
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;

    always_comb begin
        wr_be    = 4'b1111;
        wr_lanes = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                wr_be    = 4'b0001 << addr_q[1:0];
                wr_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be    = 4'b1111;
                wr_lanes = wdata_q;
            end
        endcase
    end

    // Byte-enable write port; commits at the edge that ends DONE
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[addr_q[AW+1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    // Synchronous read port, enabled only for successful loads so it holds
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rdata_q <= 32'h0;
        end else if (rd_en) begin
            rdata_q <= mem_q[acc_addr[AW+1:2]];
        end
    end

    // Control FSM with registered READY/MISALIGNED
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            ready_q  <= 1'b0;
            mis_q    <= 1'b0;
            ld_f3_q  <= 3'b000;
            ld_off_q <= 2'b00;
        end else begin
            ready_q <= 1'b0;
            mis_q   <= 1'b0;

            if (enter_done) begin
                ready_q <= 1'b1;
                mis_q   <= acc_bad;
            end

            if (rd_en) begin
                ld_f3_q  <= acc_f3;
                ld_off_q <= acc_addr[1:0];
            end

            case (state_q)
                S_IDLE: begin
                    if (REQ) begin
                        we_q    <= WE;
                        f3_q    <= FUNCT3;
                        addr_q  <= ADDRESS[AW+1:0];
                        wdata_q <= DATA_IN;
                        cnt_q   <= CW'(WAIT_STATES);
                        state_q <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Extension of the held RAM word; depends only on registers
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        case (ld_off_q)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = ld_off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (ld_f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = rdata_q;
        endcase
    end

    assign READY      = ready_q;
    assign MISALIGNED = mis_q;
    assign DATA_OUT   = ld_ext;

endmodule
